// File: rtl/core_pkg.sv
// Shared types for the issue stage: dispatch FSM state, in-flight limit
// default and the packet captured in the dispatch hold register.
package core_pkg;

  localparam int MAX_INFLIGHT_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } disp_state_e;

  typedef struct packed {
    logic [4:0]  rdAddr;
    logic        rdWe;
    logic [4:0]  rs1Addr;
    logic        rs1Re;
    logic [4:0]  rs2Addr;
    logic        rs2Re;
    logic [31:0] instAddr;
    logic [63:0] imm;
    logic [6:0]  opCode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [5:0]  shamt;
  } issue_pkt_t;

endpackage

// File: rtl/issue_dispatch_way1_if.sv
// Decode-side, register-file, EU and writeback signals of the way-1 dispatch
// stage. The slave modport is the dispatch block, master is its environment.
interface issue_dispatch_way1_if;
  logic        dec_valid_i;
  logic        dec_ready_o;
  logic [4:0]  rdAddr_i, rs1Addr_i, rs2Addr_i;
  logic        rdWriteEnable_i, rs1ReadEnable_i, rs2ReadEnable_i;
  logic [31:0] instAddr_i;
  logic [63:0] imm_i;
  logic [6:0]  opCode_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [5:0]  shamt_i;

  logic [4:0]  rfRs1Addr_o, rfRs2Addr_o;
  logic [63:0] rfRs1Data_i, rfRs2Data_i;

  logic        eu_full_i;
  logic        valid_o;
  logic [4:0]  rdAddr_o;
  logic        rdWriteEnable_o;
  logic [31:0] instAddr_o;
  logic [63:0] rs1ReadData_o, rs2ReadData_o;
  logic [63:0] imm_o;
  logic [6:0]  opCode_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [5:0]  shamt_o;
  logic [1:0]  way1_pID_o;

  logic        wbValid_i;
  logic [4:0]  wbRdAddr_i;
  logic        jumpFlag_i;

  modport slave (
    input  dec_valid_i, rdAddr_i, rs1Addr_i, rs2Addr_i,
           rdWriteEnable_i, rs1ReadEnable_i, rs2ReadEnable_i,
           instAddr_i, imm_i, opCode_i, funct3_i, funct7_i, shamt_i,
           rfRs1Data_i, rfRs2Data_i, eu_full_i, wbValid_i, wbRdAddr_i, jumpFlag_i,
    output dec_ready_o, rfRs1Addr_o, rfRs2Addr_o, valid_o,
           rdAddr_o, rdWriteEnable_o, instAddr_o, rs1ReadData_o, rs2ReadData_o,
           imm_o, opCode_o, funct3_o, funct7_o, shamt_o, way1_pID_o
  );

  modport master (
    output dec_valid_i, rdAddr_i, rs1Addr_i, rs2Addr_i,
           rdWriteEnable_i, rs1ReadEnable_i, rs2ReadEnable_i,
           instAddr_i, imm_i, opCode_i, funct3_i, funct7_i, shamt_i,
           rfRs1Data_i, rfRs2Data_i, eu_full_i, wbValid_i, wbRdAddr_i, jumpFlag_i,
    input  dec_ready_o, rfRs1Addr_o, rfRs2Addr_o, valid_o,
           rdAddr_o, rdWriteEnable_o, instAddr_o, rs1ReadData_o, rs2ReadData_o,
           imm_o, opCode_o, funct3_o, funct7_o, shamt_o, way1_pID_o
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Destination-register busy bits plus the count of issued packets still
// awaiting writeback.
module issue_scoreboard #(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        set_i,
  input  logic [4:0]  setAddr_i,
  input  logic        clr_i,
  input  logic [4:0]  clrAddr_i,
  input  logic        flush_i,
  output logic [31:0] busy_o,
  output logic        full_o
);
  localparam int CW = $clog2(MAX_INFLIGHT) + 1;

  logic [31:0]   busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dec;

  // Clear is applied before set so a same-index set wins.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (clr_i) busy_d[clrAddr_i] = 1'b0;
      if (set_i && setAddr_i != 5'd0) busy_d[setAddr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // A writeback with nothing outstanding is stray and must not underflow.
  assign dec = clr_i && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) cnt_d = '0;
    else         cnt_d = cnt_q + CW'(set_i) - CW'(dec);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o = busy_q;
  assign full_o = (cnt_q >= CW'(MAX_INFLIGHT));
endmodule

// File: rtl/issue_dispatch_way1.sv
// Way-1 dispatch: one-entry hold register between decode and the EU buffer,
// stalling on RAW hazards, EU back-pressure and the in-flight limit.
module issue_dispatch_way1
  import core_pkg::*;
#(
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input logic                 clk,
  input logic                 reset_n,
  issue_dispatch_way1_if.slave bus
);
  disp_state_e state_q, state_d;
  issue_pkt_t  hold_q, hold_d, in_pkt;
  logic [1:0]  pid_q;
  logic [31:0] busy;
  logic        full, hazard, issue_fire, accept, dec_ready;

  assign in_pkt = '{
    rdAddr:   bus.rdAddr_i,   rdWe:   bus.rdWriteEnable_i,
    rs1Addr:  bus.rs1Addr_i,  rs1Re:  bus.rs1ReadEnable_i,
    rs2Addr:  bus.rs2Addr_i,  rs2Re:  bus.rs2ReadEnable_i,
    instAddr: bus.instAddr_i, imm:    bus.imm_i,
    opCode:   bus.opCode_i,   funct3: bus.funct3_i,
    funct7:   bus.funct7_i,   shamt:  bus.shamt_i
  };

  // No writeback bypass: a clear only unblocks the following cycle.
  assign hazard = (hold_q.rs1Re && hold_q.rs1Addr != 5'd0 && busy[hold_q.rs1Addr]) ||
                  (hold_q.rs2Re && hold_q.rs2Addr != 5'd0 && busy[hold_q.rs2Addr]);

  assign issue_fire = (state_q == HOLD) && !bus.eu_full_i && !hazard && !full && !bus.jumpFlag_i;
  assign accept     = bus.dec_valid_i && dec_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.jumpFlag_i)   state_d = IDLE;
    else if (accept)      state_d = HOLD;
    else if (issue_fire)  state_d = IDLE;
  end

  // reset_n gates ready so decode cannot see a handshake while in reset.
  always_comb begin
    dec_ready   = reset_n && ((state_q == IDLE) || issue_fire) && !bus.jumpFlag_i;
    bus.valid_o = issue_fire;
  end
  assign bus.dec_ready_o = dec_ready;

  always_comb begin
    hold_d = hold_q;
    if (bus.jumpFlag_i) hold_d = '0;
    else if (accept)    hold_d = in_pkt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
      pid_q  <= '0;
    end else begin
      hold_q <= hold_d;
      if (issue_fire) pid_q <= pid_q + 2'd1;
    end
  end

  // An address of 0 tells the scoreboard not to mark any register busy.
  issue_scoreboard #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_sb (
    .clk       (clk),
    .reset_n   (reset_n),
    .set_i     (issue_fire),
    .setAddr_i (hold_q.rdWe ? hold_q.rdAddr : 5'd0),
    .clr_i     (bus.wbValid_i),
    .clrAddr_i (bus.wbRdAddr_i),
    .flush_i   (bus.jumpFlag_i),
    .busy_o    (busy),
    .full_o    (full)
  );

  assign bus.rfRs1Addr_o     = hold_q.rs1Addr;
  assign bus.rfRs2Addr_o     = hold_q.rs2Addr;
  assign bus.rdAddr_o        = hold_q.rdAddr;
  assign bus.rdWriteEnable_o = hold_q.rdWe;
  assign bus.instAddr_o      = hold_q.instAddr;
  assign bus.imm_o           = hold_q.imm;
  assign bus.opCode_o        = hold_q.opCode;
  assign bus.funct3_o        = hold_q.funct3;
  assign bus.funct7_o        = hold_q.funct7;
  assign bus.shamt_o         = hold_q.shamt;
  assign bus.rs1ReadData_o   = issue_fire ? bus.rfRs1Data_i : 64'd0;
  assign bus.rs2ReadData_o   = issue_fire ? bus.rfRs2Data_i : 64'd0;
  assign bus.way1_pID_o      = pid_q;
endmodule

// File: tb/tb_issue_dispatch_way1.sv
// Directed scenarios plus random traffic against a queue/array model of the
// dispatch stage; every cycle is compared at #1 after the falling edge.
module tb_issue_dispatch_way1;
  import core_pkg::*;

  localparam int MAXI = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  issue_dispatch_way1_if bus();
  issue_dispatch_way1 #(.MAX_INFLIGHT(MAXI)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: held packet queue (0 or 1 entries), busy flags, counts.
  issue_pkt_t mq[$];
  bit         busy_m[32];
  int         outst, pid;

  task automatic model_reset();
    mq.delete();
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    outst = 0;
    pid   = 0;
  endtask

  function automatic issue_pkt_t in_pkt();
    issue_pkt_t p;
    p.rdAddr = bus.rdAddr_i;     p.rdWe   = bus.rdWriteEnable_i;
    p.rs1Addr = bus.rs1Addr_i;   p.rs1Re  = bus.rs1ReadEnable_i;
    p.rs2Addr = bus.rs2Addr_i;   p.rs2Re  = bus.rs2ReadEnable_i;
    p.instAddr = bus.instAddr_i; p.imm    = bus.imm_i;
    p.opCode = bus.opCode_i;     p.funct3 = bus.funct3_i;
    p.funct7 = bus.funct7_i;     p.shamt  = bus.shamt_i;
    return p;
  endfunction

  task automatic idle_in();
    bus.dec_valid_i = 1'b0;
    bus.wbValid_i   = 1'b0;
    bus.wbRdAddr_i  = 5'd0;
    bus.jumpFlag_i  = 1'b0;
    bus.eu_full_i   = 1'b0;
  endtask

  task automatic put(input logic [4:0] rd, input logic we, input logic [4:0] r1, input logic re1,
                     input logic [4:0] r2, input logic re2);
    bus.dec_valid_i = 1'b1;
    bus.rdAddr_i = rd;  bus.rdWriteEnable_i = we;
    bus.rs1Addr_i = r1; bus.rs1ReadEnable_i = re1;
    bus.rs2Addr_i = r2; bus.rs2ReadEnable_i = re2;
    bus.instAddr_i = $urandom;
    bus.imm_i      = {$urandom, $urandom};
    bus.opCode_i   = 7'($urandom);
    bus.funct3_i   = 3'($urandom);
    bus.funct7_i   = 7'($urandom);
    bus.shamt_i    = 6'($urandom);
  endtask

  // Called at a falling edge with inputs applied; checks, advances the model
  // across the next rising edge and returns at the following falling edge.
  task automatic cyc();
    bit haz, fire, rdy, dec;
    issue_pkt_t p;
    bus.rfRs1Data_i = {$urandom, $urandom};
    bus.rfRs2Data_i = {$urandom, $urandom};
    #1;
    haz = 1'b0; fire = 1'b0; p = '0;
    if (mq.size() > 0) begin
      p    = mq[0];
      haz  = (p.rs1Re && p.rs1Addr != 0 && busy_m[p.rs1Addr]) ||
             (p.rs2Re && p.rs2Addr != 0 && busy_m[p.rs2Addr]);
      fire = !bus.eu_full_i && !haz && (outst < MAXI) && !bus.jumpFlag_i;
    end
    rdy = (mq.size() == 0 || fire) && !bus.jumpFlag_i;
    chk("valid_o", bus.valid_o, fire);
    chk("dec_ready_o", bus.dec_ready_o, rdy);
    if (mq.size() > 0) chk("rfRs1Addr_o", bus.rfRs1Addr_o, p.rs1Addr);
    if (fire) begin
      chk("rdAddr_o", bus.rdAddr_o, p.rdAddr);
      chk("rdWriteEnable_o", bus.rdWriteEnable_o, p.rdWe);
      chk("instAddr_o", bus.instAddr_o, p.instAddr);
      chk("imm_o", bus.imm_o, p.imm);
      chk("opCode_o", bus.opCode_o, p.opCode);
      chk("funct3_o", bus.funct3_o, p.funct3);
      chk("funct7_o", bus.funct7_o, p.funct7);
      chk("shamt_o", bus.shamt_o, p.shamt);
      chk("rfRs2Addr_o", bus.rfRs2Addr_o, p.rs2Addr);
      chk("rs1ReadData_o", bus.rs1ReadData_o, bus.rfRs1Data_i);
      chk("rs2ReadData_o", bus.rs2ReadData_o, bus.rfRs2Data_i);
      chk("way1_pID_o", bus.way1_pID_o, pid);
    end
    if (bus.jumpFlag_i) begin
      mq.delete();
      foreach (busy_m[i]) busy_m[i] = 1'b0;
      outst = 0;
    end else begin
      dec = bus.wbValid_i && outst > 0;
      if (bus.wbValid_i) busy_m[bus.wbRdAddr_i] = 1'b0;
      if (fire) begin
        if (p.rdWe && p.rdAddr != 0) busy_m[p.rdAddr] = 1'b1;
        void'(mq.pop_front());
        pid = (pid + 1) % 4;
      end
      outst = outst + int'(fire) - int'(dec);
      if (rdy && bus.dec_valid_i) mq.push_back(in_pkt());
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, bus.valid_o, 1'b0);
    chk({tag, "_ready"}, bus.dec_ready_o, 1'b0);
    chk({tag, "_rd"}, bus.rdAddr_o, 5'd0);
    chk({tag, "_pc"}, bus.instAddr_o, 32'd0);
    chk({tag, "_imm"}, bus.imm_o, 64'd0);
    chk({tag, "_rs1data"}, bus.rs1ReadData_o, 64'd0);
    chk({tag, "_pid"}, bus.way1_pID_o, 2'd0);
  endtask

  task automatic flush_cyc();
    idle_in();
    bus.jumpFlag_i = 1'b1;
    cyc();
    idle_in();
  endtask

  initial begin
    reset_n = 1'b0;
    idle_in();
    put(5'd3, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1);
    bus.rfRs1Data_i = 64'hdead; bus.rfRs2Data_i = 64'hbeef;
    repeat (2) @(negedge clk);
    #1 chk_reset_outputs("reset");
    reset_n = 1'b1;
    model_reset();
    idle_in();
    @(negedge clk);

    // Back-to-back: four packets, pIDs 0..3 in consecutive cycles
    for (int i = 0; i < 4; i++) begin
      put(5'(10 + i), 1'b1, 5'd20, 1'b0, 5'd21, 1'b0);
      cyc();
    end
    idle_in();
    repeat (2) cyc();
    flush_cyc();

    // RAW on x5, released one cycle after its writeback
    put(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); cyc();
    put(5'd6, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0); cyc();
    idle_in(); repeat (3) cyc();
    bus.wbValid_i = 1'b1; bus.wbRdAddr_i = 5'd5; cyc();
    idle_in(); repeat (2) cyc();
    flush_cyc();

    // In-flight limit, released by a single writeback
    for (int i = 0; i < 5; i++) begin
      put(5'(i + 1), 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      cyc();
    end
    idle_in(); repeat (2) cyc();
    bus.wbValid_i = 1'b1; bus.wbRdAddr_i = 5'd1; cyc();
    idle_in(); repeat (2) cyc();
    flush_cyc();

    // EU back-pressure for three cycles
    put(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); cyc();
    idle_in(); bus.eu_full_i = 1'b1; repeat (3) cyc();
    bus.eu_full_i = 1'b0; cyc();
    cyc();
    flush_cyc();

    // Flush during a hazard stall, then a dependent packet issues at once
    put(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); cyc();
    put(5'd8, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0); cyc();
    idle_in(); cyc();
    flush_cyc();
    put(5'd9, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0); cyc();
    idle_in(); repeat (2) cyc();
    flush_cyc();

    // x0 destination never becomes busy
    put(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); cyc();
    put(5'd3, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1); cyc();
    idle_in(); repeat (2) cyc();
    flush_cyc();

    // Reset while a hazard-stalled packet is held
    put(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); cyc();
    put(5'd6, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0); cyc();
    idle_in(); cyc();
    reset_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (3) cyc();

    // Random traffic on a small register window to provoke hazards
    for (int n = 0; n < 800; n++) begin
      put(5'($urandom % 8), 1'($urandom), 5'($urandom % 8), 1'($urandom),
          5'($urandom % 8), 1'($urandom));
      bus.dec_valid_i = ($urandom % 4) != 0;
      bus.eu_full_i   = ($urandom % 5) == 0;
      bus.wbValid_i   = ($urandom % 3) == 0;
      bus.wbRdAddr_i  = 5'($urandom % 8);
      bus.jumpFlag_i  = ($urandom % 40) == 0;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/issue_dispatch_way1.md
ISSUE_DISPATCH_WAY1 -- requirements
Module: issue_dispatch_way1

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 4: maximum number of issued packets without writeback.
REQ-002 SHALL have these ports; clock and reset are decided as reset_n, asynchronous, active-low, and clock clk:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- dec_valid_i  in  1  decode packet valid.
- dec_ready_o  out  1  dispatch can accept a packet.
- rdAddr_i, rs1Addr_i, rs2Addr_i  in  5 each  register indices.
- rdWriteEnable_i, rs1ReadEnable_i, rs2ReadEnable_i  in  1 each  usage flags.
- instAddr_i  in  32  PC.
- imm_i  in  64  immediate.
- opCode_i  in  7  opcode.
- funct3_i  in  3  funct3 field.
- funct7_i  in  7  funct7 field.
- shamt_i  in  6  shift amount.
- rfRs1Addr_o, rfRs2Addr_o  out  5 each  register-file read addresses, taken from the hold register.
- rfRs1Data_i, rfRs2Data_i  in  64 each  combinational register-file read data.
- eu_full_i  in  1  EU register buffer is full.
- valid_o  out  1  issue strobe, which is the write increment into the EU register buffer.
- rdAddr_o, rdWriteEnable_o, instAddr_o, rs1ReadData_o, rs2ReadData_o, imm_o, opCode_o, funct3_o, funct7_o, shamt_o  out  widths as the inputs  issued packet.
- way1_pID_o  out  2  packet tag.
- wbValid_i  in  1  writeback event.
- wbRdAddr_i  in  5  writeback destination register.
- jumpFlag_i  in  1  flush.

Function
REQ-003 SHALL use a two-state FSM:
- IDLE: the hold register is empty.
- HOLD: the hold register contains a packet.
REQ-004 SHALL set dec_ready_o = (state==IDLE) || issue_fire, and this signal SHALL be false while jumpFlag_i is high.
REQ-005 SHALL capture the packet into the hold register on dec_valid_i && dec_ready_o, and the state SHALL become HOLD.
REQ-006 SHALL compute issue_fire = HOLD && !eu_full_i && !hazard && (outstanding < MAX_INFLIGHT) && !jumpFlag_i.
REQ-007 SHALL raise hazard when either condition holds:
- rs1ReadEnable && busy[rs1Addr] && rs1Addr != 0.
- rs2ReadEnable && busy[rs2Addr] && rs2Addr != 0.
REQ-008 SHALL drive valid_o = issue_fire combinationally; each issue SHALL produce exactly one valid_o cycle.
REQ-009 SHALL drive packet outputs directly from the hold register, and rs1ReadData_o/rs2ReadData_o SHALL be rfRs1Data_i/rfRs2Data_i passed through in the issue cycle.
REQ-010 SHALL give a minimum latency of 1 cycle: a packet accepted at edge N SHALL be able to issue in cycle N+1.
REQ-011 SHALL on issue_fire without a new accept return to IDLE; with a same-cycle accept it SHALL stay in HOLD with the new packet (back-to-back issue every cycle).
REQ-012 SHALL maintain a 32-bit busy vector:
- On issue with rdWriteEnable && rdAddr != 0, set busy[rdAddr].
- On wbValid_i, clear busy[wbRdAddr_i].
- On simultaneous set and clear of the same index, set wins.
- busy[0] is always 0.
REQ-013 SHALL evaluate hazard against the registered busy vector with no writeback bypass; a clear becomes visible in the next cycle.
REQ-014 SHALL maintain an outstanding counter of width clog2(MAX_INFLIGHT)+1:
- +1 on issue, -1 on wbValid_i, unchanged when both occur.
- It never exceeds MAX_INFLIGHT and never underflows; wbValid_i at 0 is ignored.
REQ-015 SHALL keep a 2-bit pID counter, output as way1_pID_o, that increments after every issue and wraps 3->0.
REQ-016 SHALL on jumpFlag_i in any state, at the next edge:
- Discard the hold packet and go to IDLE.
- Clear the busy vector.
- Zero the outstanding counter.
- Keep the pID counter.
- Not issue in that cycle.
REQ-017 SHALL hold all state unchanged while the FSM is stalled, whether by hazard, eu_full_i or the outstanding limit.

Reset
REQ-018 SHALL on reset_n low put state in IDLE and zero busy, outstanding, pID and all hold-register fields.
REQ-019 SHALL during reset drive valid_o=0, drive dec_ready_o=0, and drive all packet outputs to 0.
REQ-020 SHALL, if reset is asserted mid-stall, lose the pending packet without emitting valid_o.

Structure
REQ-021 SHALL take the FSM state enum, MAX_INFLIGHT default and the issue packet struct from a shared package, core_pkg.
REQ-022 SHALL implement the busy vector and outstanding counter in one sub-module, issue_scoreboard, with interface: set, setAddr, clr, clrAddr, flush, busy[31:0], full.

Verification
REQ-023 SHALL cover back-to-back issue: dec_valid_i held 4 cycles with no hazards and eu_full_i=0 -> valid_o high in cycles 1..4, way1_pID_o = 0,1,2,3.
REQ-024 SHALL cover a RAW hazard: issue rd=5, then a packet with rs1=5 -> no valid_o until wbValid_i with wbRdAddr_i=5; issue occurs one cycle after the wb cycle.
REQ-025 SHALL cover the outstanding limit: 4 issues with no writeback, then a 5th packet -> stalled with dec_ready_o=0; one wbValid_i -> the 5th issues next cycle.
REQ-026 SHALL cover back-pressure: eu_full_i=1 for 3 cycles with a packet held -> valid_o=0 and outputs stable; issue occurs in the cycle eu_full_i falls.
REQ-027 SHALL cover flush: jumpFlag_i during a hazard stall -> no valid_o, next cycle IDLE with busy=0, and a following rs1=5 packet issues immediately.
REQ-028 SHALL cover the x0 rule: rd=0 with write enable -> busy stays 0, and a following rs1=0 packet is not stalled.
